// File: rtl/alu_serial_ctrl_if.sv
// Request/response and slice-side signals of the bit-serial ALU sequencer.
// The slave modport is the sequencer. The master modport is its requester plus the external 1-bit slice.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       f;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic [1:0]       slice_f;
  logic             slice_out;
  logic             slice_cout;

  modport master (
    output start, f, a, b, cin, slice_out, slice_cout,
    input  busy, done, result, cout, slice_a, slice_b, slice_cin, slice_f
  );

  modport slave (
    input  start, f, a, b, cin, slice_out, slice_cout,
    output busy, done, result, cout, slice_a, slice_b, slice_cin, slice_f
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice (NOT/OR/AND/ADD).
// It walks the operands LSB-first and ripples the carry through a register.
//   state  | meaning
//   S_IDLE | waiting for start; slice inputs parked at 0
//   S_RUN  | presenting bit r_idx to the slice and capturing its result
//   S_DONE | one-cycle done pulse; carry moves into cout
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_serial_ctrl_if.slave   bus
);
  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_f;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             w_last;
  logic             w_is_add;

  assign w_last   = (r_idx == LAST_IDX);
  assign w_is_add = (r_f == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.slice_a   = 1'b0;
    bus.slice_b   = 1'b0;
    bus.slice_cin = 1'b0;
    bus.slice_f   = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_RUN;
      end
      S_RUN: begin
        bus.busy      = 1'b1;
        bus.slice_a   = r_a[r_idx];
        bus.slice_b   = r_b[r_idx];
        bus.slice_cin = r_carry;
        bus.slice_f   = r_f;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Carry is forced to 0 for logic ops, so cout needs no op check at DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_f      <= 2'b00;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_f      <= bus.f;
            r_carry  <= (bus.f == 2'b11) & bus.cin;
            r_idx    <= '0;
            r_result <= '0;
          end
        end
        S_RUN: begin
          r_result[r_idx] <= bus.slice_out;
          r_carry         <= w_is_add & bus.slice_cout;
          if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
        S_DONE: begin
          r_cout <= r_carry;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.cout   = r_cout;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed and random checks of alu_serial_ctrl with a behavioural 1-bit slice.
module tb_alu_serial_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_serial_ctrl_if #(.WIDTH(8)) bus ();

  alu_serial_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External slice: f=00 NOT a, 01 OR, 10 AND, 11 full add.
  always_comb begin
    bus.slice_out  = 1'b0;
    bus.slice_cout = 1'b0;
    case (bus.slice_f)
      2'b00: bus.slice_out = ~bus.slice_a;
      2'b01: bus.slice_out = bus.slice_a | bus.slice_b;
      2'b10: bus.slice_out = bus.slice_a & bus.slice_b;
      default: begin
        bus.slice_out  = bus.slice_a ^ bus.slice_b ^ bus.slice_cin;
        bus.slice_cout = (bus.slice_a & bus.slice_b) | (bus.slice_a & bus.slice_cin) |
                         (bus.slice_b & bus.slice_cin);
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_cout"}, 32'(bus.cout), 32'd0);
    check({tag, "_slice"}, {28'd0, bus.slice_a, bus.slice_b, bus.slice_cin, 1'b0} | 32'(bus.slice_f), 32'd0);
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns at #1 in the cycle after done.
  task automatic run_op(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] exp_res, input logic exp_cout);
    logic       carry;
    int         lat;
    int         busy_n;
    logic [7:0] res;
    bus.start = 1'b1;
    bus.f     = f;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    carry  = (f == 2'b11) ? cin : 1'b0;
    lat    = 0;
    busy_n = 0;
    res    = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = c;
        res = bus.result;
        break;
      end
      if (c <= 8) begin
        check("slice_a", 32'(bus.slice_a), 32'(a[c-1]));
        check("slice_b", 32'(bus.slice_b), 32'(b[c-1]));
        check("slice_cin", 32'(bus.slice_cin), 32'(carry));
        check("slice_f", 32'(bus.slice_f), 32'(f));
        if (f == 2'b11)
          carry = (a[c-1] & b[c-1]) | (a[c-1] & carry) | (b[c-1] & carry);
      end
      @(posedge clk); #1;
    end
    check("done_latency", 32'(lat), 32'd9);
    check("busy_cycles", 32'(busy_n), 32'd9);
    check("result", 32'(res), 32'(exp_res));
    @(posedge clk); #1;
    check("done_single", 32'(bus.done), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
    check("cout", 32'(bus.cout), 32'(exp_cout));
    check("result_held", 32'(bus.result), 32'(exp_res));
  endtask

  typedef struct {
    logic [1:0] f;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int         done_n;
    logic [7:0] res;
    logic [1:0] rf;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] sum;
    logic [7:0] er;
    logic       ec;

    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{2'b11, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{2'b11, 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0};
    vecs[2] = '{2'b00, 8'hA5, 8'h3C, 1'b1, 8'h5A, 1'b0};
    vecs[3] = '{2'b01, 8'hA0, 8'h0F, 1'b1, 8'hAF, 1'b0};
    vecs[4] = '{2'b10, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0};
    vecs[5] = '{2'b11, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{2'b11, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{2'b11, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[8] = '{2'b01, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[9] = '{2'b00, 8'h00, 8'hFF, 1'b0, 8'hFF, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.f     = 2'b00;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].cout);

    // Second start during RUN must be ignored.
    bus.start = 1'b1;
    bus.f = 2'b11; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_n = 0;
    res    = 8'h00;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) begin
        done_n++;
        res = bus.result;
      end
      @(posedge clk); #1;
    end
    check("restart_done_count", 32'(done_n), 32'd1);
    check("restart_result", 32'(res), 32'h30);
    check("restart_cout", 32'(bus.cout), 32'd0);
    check("restart_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset while bit 4 is on the slice.
    bus.start = 1'b1;
    bus.f = 2'b11; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    check("pre_rst_result", 32'(bus.result), 32'h0F);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrun_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    done_n = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done) done_n++;
      @(posedge clk); #1;
    end
    check("aborted_no_done", 32'(done_n), 32'd0);
    run_op(2'b11, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Back-to-back random operations against an arithmetic model.
    for (int n = 0; n < 200; n++) begin
      rf  = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom_range(0, 1));
      ec  = 1'b0;
      case (rf)
        2'b00:   er = ~ra;
        2'b01:   er = ra | rb;
        2'b10:   er = ra & rb;
        default: begin
          sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
          er  = sum[7:0];
          ec  = sum[8];
        end
      endcase
      run_op(rf, ra, rb, rc, er, ec);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "timeout");
  end
endmodule
